// File: rtl/interp_job_scheduler.sv
// Purpose: round-robin job scheduler for two zoom-window requesters feeding one interpolation engine,
//          with a job FIFO, source-image range check, O_VALID beat counting and a stall watchdog.
// Latency: accept at E0, pop at E1, eng_start high E1..E2; range error done pulse E1..E2; done one cycle after last beat.
// Backpressure: reqN_ready drops while the job FIFO is full; only the arbitration winner sees ready.
//
// Ports:
//   clk, RST                     clock (rising edge), asynchronous active-high reset
//   req0_* / req1_*              valid/ready job requests: h0, v0 (6b origin), sw, sh (4b step, 1/16 px)
//   eng_start                    one-cycle START pulse to the engine
//   eng_h0/v0/sw/sh              registered job parameters, change only when a job is popped
//   eng_o_valid                  engine output beat, counted only while running a job
//   done_valid/done_src/done_code one-cycle completion: requester id, 0=OK 1=range error 2=timeout
//   busy                         FIFO non-empty or a job in flight
module interp_job_scheduler #(
    parameter int DEPTH   = 4,
    parameter int NPIX    = 289,
    parameter int TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [5:0] req0_h0,
    input  logic [5:0] req0_v0,
    input  logic [3:0] req0_sw,
    input  logic [3:0] req0_sh,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [5:0] req1_h0,
    input  logic [5:0] req1_v0,
    input  logic [3:0] req1_sw,
    input  logic [3:0] req1_sh,
    output logic       eng_start,
    output logic [5:0] eng_h0,
    output logic [5:0] eng_v0,
    output logic [3:0] eng_sw,
    output logic [3:0] eng_sh,
    input  logic       eng_o_valid,
    output logic       done_valid,
    output logic       done_src,
    output logic [1:0] done_code,
    output logic       busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;

    localparam logic [1:0] CODE_OK    = 2'd0;
    localparam logic [1:0] CODE_RANGE = 2'd1;
    localparam logic [1:0] CODE_TMO   = 2'd2;

    localparam logic [8:0] BEAT_LAST = 9'(NPIX - 1);
    localparam logic [9:0] WD_LAST   = 10'(TIMEOUT - 1);

    // FIFO entry layout: {src, h0, v0, sw, sh}
    logic [20:0] r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;

    logic        r_last;
    logic [1:0]  r_state;
    logic [5:0]  r_h0;
    logic [5:0]  r_v0;
    logic [3:0]  r_sw;
    logic [3:0]  r_sh;
    logic        r_src;
    logic [8:0]  r_beats;
    logic [9:0]  r_wd;
    logic        r_done_vld;
    logic        r_done_src;
    logic [1:0]  r_done_code;

    logic        w_full;
    logic        w_empty;
    logic        w_grant0;
    logic        w_grant1;
    logic        w_push;
    logic [20:0] w_push_dat;
    logic        w_pop;
    logic [20:0] w_head;
    logic [6:0]  w_hsum;
    logic [6:0]  w_vsum;
    logic        w_range_err;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // Round-robin: with both requesting, the one not granted last time wins.
    assign w_grant0 = req0_valid & (~req1_valid | r_last);
    assign w_grant1 = req1_valid & (~req0_valid | ~r_last);

    // Ready is held low during reset so no handshake can be seen mid-reset.
    assign req0_ready = w_grant0 & ~w_full & ~RST;
    assign req1_ready = w_grant1 & ~w_full & ~RST;

    assign w_push     = req0_ready | req1_ready;
    assign w_push_dat = w_grant1 ? {1'b1, req1_h0, req1_v0, req1_sw, req1_sh}
                                 : {1'b0, req0_h0, req0_v0, req0_sw, req0_sh};

    // Pop only reads registered FIFO contents, so a push and pop on an empty FIFO cannot coincide.
    assign w_pop  = (r_state == S_IDLE) & ~w_empty;
    assign w_head = r_mem[r_rd_ptr[AW-1:0]];

    // The engine samples up to origin + step; anything beyond pixel 62 would read outside the 64x64 source.
    assign w_hsum      = {1'b0, w_head[19:14]} + {3'b000, w_head[7:4]};
    assign w_vsum      = {1'b0, w_head[13:8]}  + {3'b000, w_head[3:0]};
    assign w_range_err = (w_hsum > 7'd62) | (w_vsum > 7'd62);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_push_dat;
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_last      <= 1'b1;
            r_state     <= S_IDLE;
            r_h0        <= '0;
            r_v0        <= '0;
            r_sw        <= '0;
            r_sh        <= '0;
            r_src       <= 1'b0;
            r_beats     <= '0;
            r_wd        <= '0;
            r_done_vld  <= 1'b0;
            r_done_src  <= 1'b0;
            r_done_code <= CODE_OK;
        end else begin
            r_done_vld <= 1'b0;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
                r_last   <= w_grant1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_rd_ptr <= r_rd_ptr + PTR_ONE;
                        r_src    <= w_head[20];
                        r_h0     <= w_head[19:14];
                        r_v0     <= w_head[13:8];
                        r_sw     <= w_head[7:4];
                        r_sh     <= w_head[3:0];
                        if (w_range_err) begin
                            r_done_vld  <= 1'b1;
                            r_done_src  <= w_head[20];
                            r_done_code <= CODE_RANGE;
                        end else begin
                            r_state <= S_LAUNCH;
                        end
                    end
                end
                S_LAUNCH: begin
                    r_beats <= '0;
                    r_wd    <= '0;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    // A beat on the same edge as the watchdog expiry takes priority.
                    if (eng_o_valid) begin
                        r_beats <= r_beats + 9'd1;
                        r_wd    <= '0;
                        if (r_beats == BEAT_LAST) begin
                            r_done_vld  <= 1'b1;
                            r_done_src  <= r_src;
                            r_done_code <= CODE_OK;
                            r_state     <= S_IDLE;
                        end
                    end else if (r_wd == WD_LAST) begin
                        r_done_vld  <= 1'b1;
                        r_done_src  <= r_src;
                        r_done_code <= CODE_TMO;
                        r_state     <= S_IDLE;
                    end else begin
                        r_wd <= r_wd + 10'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign eng_start = (r_state == S_LAUNCH);
    assign eng_h0    = r_h0;
    assign eng_v0    = r_v0;
    assign eng_sw    = r_sw;
    assign eng_sh    = r_sh;
    assign done_valid = r_done_vld;
    assign done_src   = r_done_src;
    assign done_code  = r_done_code;
    assign busy       = ~w_empty | (r_state != S_IDLE);

endmodule

// File: doc/interp_job_scheduler.md
# interp_job_scheduler

Job scheduler in front of the interpolation engine. It accepts zoom-window requests (H0, V0, SW, SH) from two requesters and arbitrates between them round-robin. Accepted jobs are queued in a small FIFO and launched one at a time on the engine's START/H0/V0/SW/SH inputs. The block counts the engine's O_VALID beats, range-checks each window against the 64x64 source image, runs a stall watchdog, and returns one tagged completion per job.

## Interface
Parameters:
- DEPTH, 4: job FIFO entries; power of two, ≥2.
- NPIX, 289: O_VALID beats per job (17x17 output grid).
- TIMEOUT, 1023: RUN-state cycles without an O_VALID beat before abort.

Ports:
- clk  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- req0_valid  in  1  requester 0 has a job.
- req0_ready  out  1  requester 0 accepted this cycle when valid&ready.
- req0_h0, req0_v0  in  6 each  window origin.
- req0_sw, req0_sh  in  4 each  step per output pixel, in 1/16 pixel.
- req1_valid, req1_ready, req1_h0, req1_v0, req1_sw, req1_sh: same as requester 0, for requester 1.
- eng_start  out  1  one-cycle START pulse to the engine.
- eng_h0, eng_v0  out  6 each  registered job origin, stable from launch until done.
- eng_sw, eng_sh  out  4 each  registered job step, stable from launch until done.
- eng_o_valid  in  1  engine O_VALID.
- done_valid  out  1  one-cycle completion pulse.
- done_src  out  1  requester id of the completed job.
- done_code  out  2  0 = OK, 1 = range error (engine not started), 2 = timeout.
- busy  out  1  FIFO non-empty or state ≠ IDLE.

## Operation
- Arbitration:
  - Pointer `last` holds the last granted requester; reset value 1, so requester 0 wins first.
  - When both are valid, the requester ≠ `last` wins. When one is valid, it wins.
  - reqN_ready = (grant==N) & !fifo_full. This is combinational from valid and FIFO state; the loser's ready = 0.
  - `last` updates only on an actual acceptance.
  - At most one push per cycle. Entry = {src, h0, v0, sw, sh}, 21 bits.
- FIFO:
  - DEPTH entries, pointers one bit wider than the index, wrap naturally.
  - Push and pop in the same cycle when full: the pop frees a slot, but ready is computed from the pre-edge full flag, so no push occurs that cycle.
  - Push and pop in the same cycle when empty is impossible, because pop reads only registered contents.
- FSM states: IDLE, LAUNCH, RUN.
  - IDLE, FIFO non-empty: pop the head into the job registers.
    - If h0+sw > 62 or v0+sh > 62 (7-bit sums): done_valid=1 with code 1 next cycle; stay in IDLE.
    - Otherwise go to LAUNCH.
  - LAUNCH: eng_start=1 for exactly this cycle; clear beat counter and watchdog; go to RUN.
  - RUN: each eng_o_valid increments the 9-bit beat counter and clears the watchdog.
    - When the counter reaches NPIX: done_valid, code 0, go to IDLE.
    - When the watchdog (10 bits) reaches TIMEOUT with no beat: done_valid, code 2, go to IDLE.
    - Beat and timeout on the same edge: the beat wins.
  - eng_o_valid outside RUN is ignored.
- Reset, including mid-job: FIFO emptied, all jobs dropped without a done pulse, state IDLE.

## Timing
- Reset values: req0_ready=0, req1_ready=0, eng_start=0, eng_h0=0, eng_v0=0, eng_sw=0, eng_sh=0, done_valid=0, done_src=0, done_code=0, busy=0.
- Acceptance at edge E0 → entry visible after E0 → pop at E1 (if IDLE) → eng_start high E1..E2.
- Range error: done pulse E1..E2, no eng_start.
- Completion: the NPIX-th beat is sampled at edge Ek. done_valid is high Ek..Ek+1, and state is IDLE after Ek. The next queued job launches with eng_start high Ek+1..Ek+2.
- done_src and done_code are valid only while done_valid=1; otherwise they hold their last value.
- eng_* parameters change only at a pop edge.

## Test plan
- Single job: req0 {h0=10, v0=20, sw=8, sh=8}, engine model emits 289 beats → one eng_start carrying those values; done_valid after beat 289 with src=0, code=0; busy low the following cycle.
- Simultaneous requests: req0 and req1 held valid for 4 jobs each → grants alternate 0,1,0,1; completions are in grant order with matching done_src.
- Backpressure: engine stalled in RUN, 6 req0 jobs offered → 4 accepted while the engine job is running, so FIFO full; req0_ready=0 until the first completion, then exactly one more acceptance per freed slot.
- Range check: {h0=60, sw=3} → done code=1 one cycle after the pop, eng_start never asserted. {h0=59, sw=3} → launched normally.
- Watchdog: engine emits 100 beats then stops → done code=2 exactly TIMEOUT cycles after the last beat; the next queued job then launches.
- Reset mid-RUN with 2 jobs queued: RST pulse → all outputs at reset values, FIFO empty, no done pulse. A new request afterwards launches normally.
